// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, runs a single-outstanding
// request/ack handshake to instruction memory, delivers words to IF/ID,
// and buffers one extra word when IF/ID stalls.
//
// Branches use a one-instruction delay slot. A branch seen while a fetch is
// still in flight is parked in br_pend/br_tgt and applied at the next
// completion.
//
// A flush that lands on an in-flight, non-completing request cannot move
// inst_addr. Requests are never withdrawn, and the address must stay stable
// while inst_req is high. So the flush target is held in redir_q, and the
// PC takes that value when the discarded ack arrives (DRAIN state).
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    input  logic        flush,
    input  logic [31:0] new_pc,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_ack,
    input  logic [31:0] inst_rdata,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 4;

    // RESET: idle after reset; REQ: fetch outstanding;
    // HOLD: skid full, no request; DRAIN: in-flight fetch will be discarded
    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_REQ   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    state_e            state_q;
    logic              inst_req_q;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   redir_q;
    logic              br_pend_q;
    logic [XLEN-1:0]   br_tgt_q;
    logic              if_valid_q;
    logic [XLEN-1:0]   if_inst_q;
    logic [XLEN-1:0]   if_pc_q;
    logic [XLEN-1:0]   skid_inst_q;
    logic [XLEN-1:0]   skid_pc_q;

    logic              fire_c;
    logic              branch_c;
    logic              consume_c;
    logic              slot_free_c;
    logic [XLEN-1:0]   pc_d;

    // Edge events and the PC that follows a normal completion
    always_comb begin
        fire_c      = inst_req_q & inst_ack;
        branch_c    = branch_flag & ~stall;
        consume_c   = if_valid_q & ~stall;
        slot_free_c = ~if_valid_q | consume_c;
        pc_d        = pc_q + XLEN'(ILEN);
        if (branch_c) begin
            pc_d = branch_target;
        end else if (br_pend_q) begin
            pc_d = br_tgt_q;
        end
    end

    // Fetch sequencer: priority rst > flush > branch > stall/sequential
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_RESET;
            inst_req_q  <= 1'b0;
            pc_q        <= RESET_PC;
            redir_q     <= '0;
            br_pend_q   <= 1'b0;
            br_tgt_q    <= '0;
            if_valid_q  <= 1'b0;
            if_inst_q   <= '0;
            if_pc_q     <= '0;
            skid_inst_q <= '0;
            skid_pc_q   <= '0;
        end else if (flush) begin
            if_valid_q <= 1'b0;
            br_pend_q  <= 1'b0;
            if (inst_req_q && !inst_ack) begin
                state_q <= ST_DRAIN;
                redir_q <= new_pc;
            end else begin
                state_q    <= ST_REQ;
                inst_req_q <= 1'b1;
                pc_q       <= new_pc;
            end
        end else begin
            case (state_q)
                ST_RESET: begin
                    state_q    <= ST_REQ;
                    inst_req_q <= 1'b1;
                    if (branch_c) begin
                        br_pend_q <= 1'b1;
                        br_tgt_q  <= branch_target;
                    end
                end
                ST_REQ: begin
                    if (fire_c) begin
                        pc_q      <= pc_d;
                        br_pend_q <= 1'b0;
                        if (slot_free_c) begin
                            if_valid_q <= 1'b1;
                            if_inst_q  <= inst_rdata;
                            if_pc_q    <= pc_q;
                        end else begin
                            skid_inst_q <= inst_rdata;
                            skid_pc_q   <= pc_q;
                            inst_req_q  <= 1'b0;
                            state_q     <= ST_HOLD;
                        end
                    end else begin
                        if (branch_c) begin
                            br_pend_q <= 1'b1;
                            br_tgt_q  <= branch_target;
                        end
                        if (consume_c) begin
                            if_valid_q <= 1'b0;
                        end
                    end
                end
                ST_HOLD: begin
                    if (branch_c) begin
                        br_pend_q <= 1'b1;
                        br_tgt_q  <= branch_target;
                    end
                    if (consume_c) begin
                        if_valid_q <= 1'b1;
                        if_inst_q  <= skid_inst_q;
                        if_pc_q    <= skid_pc_q;
                        inst_req_q <= 1'b1;
                        state_q    <= ST_REQ;
                    end
                end
                ST_DRAIN: begin
                    if (branch_c) begin
                        br_pend_q <= 1'b1;
                        br_tgt_q  <= branch_target;
                    end
                    if (consume_c) begin
                        if_valid_q <= 1'b0;
                    end
                    if (fire_c) begin
                        pc_q    <= redir_q;
                        state_q <= ST_REQ;
                    end
                end
                default: begin
                    state_q    <= ST_RESET;
                    inst_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign inst_req  = inst_req_q;
    assign inst_addr = pc_q;
    assign if_valid  = if_valid_q;
    assign if_inst   = if_inst_q;
    assign if_pc     = if_pc_q;

endmodule

// File: doc/if_fetch_ctrl.md
# if_fetch_ctrl

Instruction-fetch controller owning the program counter and the instruction-memory request handshake. It issues one outstanding fetch at a time, delivers fetched words to the IF/ID boundary, and absorbs pipeline stalls with a one-entry skid buffer. It applies branch redirects with a one-instruction delay slot and exception/flush redirects with in-flight discard. It replaces a free-running PC with a stall- and wait-state-aware sequencer in front of instruction ROM.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-low (0 = reset)
- stall  in  1  IF/ID must hold; a word on if_* is consumed at an edge where if_valid=1 and stall=0
- branch_flag  in  1  branch taken in ID; ignored while stall=1
- branch_target  in  32  branch destination
- flush  in  1  exception/flush; highest priority, honoured regardless of stall
- new_pc  in  32  flush destination
- inst_req  out  1  registered fetch request
- inst_addr  out  32  fetch address, equals PC register, stable while inst_req=1
- inst_ack  in  1  memory done; may be high in the same cycle inst_req first rises
- inst_rdata  in  32  instruction word, valid when inst_ack=1
- if_valid  out  1  if_inst/if_pc hold a live instruction
- if_inst  out  32  delivered instruction
- if_pc  out  32  address of if_inst

## Operation
- Reset (rst=0 at edge): pc=RESET_PC, inst_req=0, if_valid=0, if_inst=0, if_pc=0; skid, drop, br_pend cleared.
- First edge with rst=1: inst_req<=1, inst_addr=RESET_PC.
- Completion: edge with inst_req=1 and inst_ack=1. Unless drop=1, word {pc, inst_rdata} goes to if_* when the output slot is free after this edge (if_valid=0 or consumed this edge), else into skid. Next pc = br_tgt if delay slot just completed, else pc+4 (mod 2^32 wrap, 32'hFFFF_FFFC -> 0).
- Request issue: after any edge with no request left in flight, inst_req<=1 iff skid is empty after that edge. inst_req never drops without inst_ack (or reset). Requests are never withdrawn.
- Skid: filled only at completion while if_valid=1 and stall=1. Drains into if_* at the first edge with stall=0. The next request issues in that same edge's update.
- Branch (branch_flag=1, stall=0, flush=0): the instruction completing at or after this edge is the delay slot and is delivered normally. If a completion occurs this edge, pc<=branch_target directly. Otherwise br_pend=1 and br_tgt=branch_target; the next completion loads pc<=br_tgt and clears br_pend. A second branch while br_pend=1 overwrites br_tgt.
- Flush (flush=1): if_valid<=0, skid emptied, br_pend cleared, pc<=new_pc. If a request is in flight and not completing this edge, drop<=1: that request's completion is discarded, then a request to new_pc issues. If completing this edge, data is discarded and inst_req<=1 to new_pc next cycle.
- Priority per edge: rst > flush > branch > stall/sequential.
- States: RESET, REQ (inst_req=1), HOLD (skid full, no request), DRAIN (drop=1, awaiting discarded ack). FLUSH from any state goes to REQ (or DRAIN if an ack is outstanding).

## Timing
- Zero-wait memory (ack same cycle as req), stall=0: one instruction per cycle. if_pc sequence RESET_PC, +4, +8 from the second edge after reset release.
- N wait states: each fetch occupies N+1 cycles. if_valid pulses one cycle per fetch when stall=0.
- if_* update one edge after completion. if_* and inst_addr are fully registered.
- Stall never loses or duplicates an instruction. At most one word in skid plus one in if_*.
- Flush to first new if_valid: 2 cycles zero-wait, plus remaining wait states of the dropped fetch.

## Test plan
- Reset release, ack tied 1, stall 0 -> if_pc 0x0,0x4,0x8 on consecutive cycles; if_inst matches ROM; inst_req stays 1.
- Ack after 2 wait states -> inst_addr stable 3 cycles per fetch; if_valid high every third cycle.
- stall=1 for 3 cycles at if_pc=0x8 with ack=1 -> 0x8 held, 0xC in skid, inst_req=0. Release -> 0xC then 0x10, no gaps or duplicates.
- branch_flag at if_pc=0x10, target 0x100, zero-wait -> if_pc 0x10, 0x14 (delay slot), 0x100, 0x104.
- flush new_pc=0x180 while fetch of 0x20 outstanding with 3 wait states -> 0x20 never valid; next valid if_pc 0x180.
- rst=0 mid-wait-state with skid full -> all outputs at reset values next cycle; fetch restarts at RESET_PC; stale ack ignored.
